// File: rtl/pagerank_pkg.sv
// Shared definitions for the PageRank datapath (mapper and reducer).
//
// Contents:
//   NBITS    default word width of mapper products, bias and rank results
//   state_t  reducer control states: IDLE (waiting for a group's first beat),
//            ACCUM (summing the rest of the group), DONE (presenting the result)
package pagerank_pkg;

  localparam int NBITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pagerank_reducer.sv
// PageRank reducer: folds the mapper's stream of partial products into one
// rank word per destination node.
//
// A group is a run of accepted beats that ends with in_last. The result is
// bias + sum(in_msg) (mod 2^nbits). bias is taken from the group's first
// accepted beat. out_cnt is the number of beats in the group, saturating at
// 2^cbits-1. While a result is presented (out_val=1) no input is taken, so
// groups never overlap.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   bias     teleport term, sampled on the first accepted beat of a group
//   in_msg   partial product from the mapper
//   in_last  marks the final beat of the current group
//   in_val   in_msg/in_last valid
//   in_rdy   reducer accepts a beat this cycle (registered)
//   out_msg  reduced rank word
//   out_cnt  number of beats summed (saturating)
//   out_val  out_msg/out_cnt valid (registered)
//   out_rdy  consumer accepts the result
module pagerank_reducer
  import pagerank_pkg::*;
#(
  parameter int nbits = NBITS,
  parameter int cbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] bias,
  input  logic [nbits-1:0] in_msg,
  input  logic             in_last,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [nbits-1:0] out_msg,
  output logic [cbits-1:0] out_cnt,
  output logic             out_val,
  input  logic             out_rdy
);

  localparam logic [cbits-1:0] CNT_MAX = {cbits{1'b1}};
  localparam logic [cbits-1:0] CNT_ONE = cbits'(1);

  state_t           state_reg,   state_next;
  logic [nbits-1:0] acc_reg,     acc_next;
  logic [cbits-1:0] cnt_reg,     cnt_next;
  logic             in_rdy_reg,  in_rdy_next;
  logic             out_val_reg, out_val_next;
  logic             take;

  // A beat is only taken against the registered ready, so nothing is accepted
  // in the first cycle after reset release (in_rdy is still 0 there) and
  // in_msg contents are irrelevant whenever in_val is low.
  assign take = in_val && in_rdy_reg;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (take) begin
          acc_next   = bias + in_msg;
          cnt_next   = CNT_ONE;
          state_next = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (take) begin
          acc_next   = acc_reg + in_msg;
          cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
          state_next = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Handshake outputs are registered from the next state so they change
    // exactly on the edge that changes state.
    in_rdy_next  = (state_next != DONE);
    out_val_next = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      in_rdy_reg  <= 1'b0;
      out_val_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      in_rdy_reg  <= in_rdy_next;
      out_val_reg <= out_val_next;
    end
  end

  // acc/cnt are untouched in DONE, so the result stays stable under
  // backpressure without a separate output register.
  assign in_rdy  = in_rdy_reg;
  assign out_val = out_val_reg;
  assign out_msg = acc_reg;
  assign out_cnt = cnt_reg;

endmodule

// File: tb/tb_pagerank_reducer.sv
// Bench for pagerank_reducer. Two instances share the same input stream:
// dut with cbits=8 and dut2 with cbits=2 (to reach counter saturation with a
// short group). Expected results come from a group-level model: bias of the
// first beat plus the plain sum of the beats, count = min(beats, 2^cbits-1).
module tb_pagerank_reducer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bias = '0;
  logic [31:0] in_msg = '0;
  logic        in_last = 1'b0;
  logic        in_val = 1'b0;
  logic        out_rdy = 1'b0;

  logic        in_rdy, out_val, in_rdy2, out_val2;
  logic [31:0] out_msg, out_msg2;
  logic [7:0]  out_cnt;
  logic [1:0]  out_cnt2;

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;  // 0: out_rdy low, 1: out_rdy high, 2: random

  typedef struct packed {
    logic [31:0] msg;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] grp_q[$];
  exp_t        mon_e;

  pagerank_reducer #(.nbits(32), .cbits(8)) dut (
    .clk(clk), .reset(reset), .bias(bias), .in_msg(in_msg), .in_last(in_last),
    .in_val(in_val), .in_rdy(in_rdy), .out_msg(out_msg), .out_cnt(out_cnt),
    .out_val(out_val), .out_rdy(out_rdy)
  );

  pagerank_reducer #(.nbits(32), .cbits(2)) dut2 (
    .clk(clk), .reset(reset), .bias(bias), .in_msg(in_msg), .in_last(in_last),
    .in_val(in_val), .in_rdy(in_rdy2), .out_msg(out_msg2), .out_cnt(out_cnt2),
    .out_val(out_val2), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b0;
      1:       out_rdy = 1'b1;
      default: out_rdy = ($urandom_range(3) != 0);
    endcase
  end

  // Output monitor: scoreboard every result transfer, and check that a
  // result held under backpressure does not change.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_msg;
  logic [7:0]  prev_cnt;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_val", 64'(out_val), 64'd1);
        chk("hold_msg", 64'(out_msg), 64'(prev_msg));
        chk("hold_cnt", 64'(out_cnt), 64'(prev_cnt));
      end
      if (out_val) begin
        chk("done_in_rdy", 64'(in_rdy), 64'd0);
        chk("pair_val", 64'(out_val2), 64'd1);
      end
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("result msg=%0h cnt=%0d cnt2=%0d", out_msg, out_cnt, out_cnt2);
          chk("out_msg", 64'(out_msg), 64'(mon_e.msg));
          chk("out_cnt", 64'(out_cnt), 64'(mon_e.cnt));
          chk("out_msg2", 64'(out_msg2), 64'(mon_e.msg));
          chk("out_cnt2", 64'(out_cnt2), 64'(mon_e.cnt2));
        end
        prev_hold = 1'b0;
      end else if (out_val) begin
        prev_hold = 1'b1;
        prev_msg  = out_msg;
        prev_cnt  = out_cnt;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // Sends grp_q as one group; later beats carry random bias that must be
  // ignored. Called and returns at posedge+1.
  task automatic send_group(input logic [31:0] b, input int bubble_pct);
    logic [31:0] sum;
    exp_t        e;
    int          n;
    int          waitc;
    n   = grp_q.size();
    sum = b;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < bubble_pct) begin
        in_val  = 1'b0;
        in_msg  = $urandom;
        in_last = 1'($urandom);
        bias    = $urandom;
        @(posedge clk); #1;
      end
      in_val  = 1'b1;
      in_msg  = grp_q[i];
      in_last = (i == n - 1);
      bias    = (i == 0) ? b : $urandom;
      waitc   = 0;
      forever begin
        @(negedge clk);
        if (in_rdy) break;
        waitc++;
        if (waitc > 1000) begin
          chk("in_rdy_timeout", 64'd0, 64'd1);
          $display("test done: total=%0d bad=%0d", total, bad);
          $fatal(1, "input stalled");
        end
      end
      @(posedge clk); #1;
      sum = sum + grp_q[i];
    end
    in_val  = 1'b0;
    in_last = 1'b0;
    in_msg  = $urandom;
    e.msg   = sum;
    e.cnt   = (n > 255) ? 8'd255 : 8'(n);
    e.cnt2  = (n > 3) ? 2'd3 : 2'(n);
    exp_q.push_back(e);
    $display("group beats=%0d bias=%0h exp_msg=%0h", n, b, sum);
  endtask

  task automatic wait_out(input string tag, input logic [31:0] msg,
                          input logic [7:0] cnt, input logic [1:0] cnt2);
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (out_val) break;
    end
    chk({tag, "_val"}, 64'(out_val), 64'd1);
    chk({tag, "_msg"}, 64'(out_msg), 64'(msg));
    chk({tag, "_cnt"}, 64'(out_cnt), 64'(cnt));
    chk({tag, "_cnt2"}, 64'(out_cnt2), 64'(cnt2));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] s;
    int          n;

    in_msg = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_out_msg", 64'(out_msg), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk); #1;
    chk("first_in_rdy", 64'(in_rdy), 64'd1);

    // Reset in the middle of a group after two beats.
    in_val = 1'b1; bias = 32'd7; in_msg = 32'd11; in_last = 1'b0;
    @(posedge clk); #1;
    in_msg = 32'd12;
    @(posedge clk); #1;
    in_val = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("mid_rst_out_val", 64'(out_val), 64'd0);
    chk("mid_rst_out_msg", 64'(out_msg), 64'd0);
    chk("mid_rst_out_cnt", 64'(out_cnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("post_rst_out_val", 64'(out_val), 64'd0);

    rdy_mode = 1;
    grp_q = '{32'd5};
    send_group(32'd1, 0);
    wait_out("rst_next", 32'd6, 8'd1, 2'd1);

    // Three back-to-back beats: result in the cycle right after the last beat,
    // and gone one cycle later because out_rdy is high.
    grp_q = '{32'd3, 32'd4, 32'd5};
    send_group(32'd10, 0);
    @(negedge clk);
    chk("lat_val", 64'(out_val), 64'd1);
    chk("lat_msg", 64'(out_msg), 64'd22);
    chk("lat_cnt", 64'(out_cnt), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_val_drop", 64'(out_val), 64'd0);
    @(posedge clk); #1;

    // Backpressure: result held 5 cycles while the next group's beat waits.
    rdy_mode = 0;
    @(posedge clk); #1;
    grp_q = '{32'd1, 32'd2};
    send_group(32'd0, 0);
    grp_q = '{32'd9};
    fork
      send_group(32'd3, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_val", 64'(out_val), 64'd1);
          chk("bp_in_rdy", 64'(in_rdy), 64'd0);
          chk("bp_msg", 64'(out_msg), 64'd3);
        end
        @(posedge clk); #1;
        rdy_mode = 1;
      end
    join
    wait_out("bp_next", 32'd12, 8'd1, 2'd1);

    // Bubbles between beats; later-beat bias changes are ignored.
    grp_q = '{32'd7, 32'd8};
    send_group(32'd0, 60);
    wait_out("bubble", 32'd15, 8'd2, 2'd2);

    // Wrap-around.
    grp_q = '{32'd2};
    send_group(32'hFFFF_FFFF, 0);
    wait_out("wrap", 32'd1, 8'd1, 2'd1);

    // Counter saturation of the 2-bit instance.
    grp_q = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    send_group(32'd20, 0);
    wait_out("sat2", 32'd25, 8'd5, 2'd3);

    // Counter saturation of the 8-bit instance.
    grp_q.delete();
    s = 32'd77;
    for (int i = 0; i < 300; i++) begin
      grp_q.push_back($urandom);
      s = s + grp_q[i];
    end
    send_group(32'd77, 0);
    wait_out("sat8", s, 8'd255, 2'd3);

    // Reset while a result is waiting.
    rdy_mode = 0;
    @(posedge clk); #1;
    grp_q = '{32'd4};
    send_group(32'd4, 0);
    wait_out("done_rst", 32'd8, 8'd1, 2'd1);
    void'(exp_q.pop_back());
    #2 reset = 1'b1;
    #1;
    chk("done_rst_out_val", 64'(out_val), 64'd0);
    chk("done_rst_out_msg", 64'(out_msg), 64'd0);
    chk("done_rst_in_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Random groups with random stalls on both sides.
    rdy_mode = 2;
    for (int g = 0; g < 1000; g++) begin
      n = $urandom_range(20, 1);
      grp_q.delete();
      for (int i = 0; i < n; i++) begin
        grp_q.push_back(($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(255)));
      end
      send_group($urandom, 30);
    end

    for (int w = 0; w < 500 && exp_q.size() > 0; w++) @(posedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
